// File: rtl/mc_controller.sv
// Multicycle MIPS control FSM; 2-5 cycles/instr, memory wait states stall via mem_ready, watchdog halts after MEM_WAIT_MAX stalls.
// Optional MC_ILLEGAL_TRAP_EN: unlisted opcodes trap to HALT instead of retiring as NOPs.
module mc_controller #(
    parameter int MEM_WAIT_MAX = 255
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       memwrite,
    output logic       iord,
    output logic       irwrite,
    output logic       pcen,
    output logic [1:0] pcsrc,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic       zeroext,
    output logic       shiftreg,
    output logic       regdst,
    output logic       memtoreg,
    output logic       regwrite,
    output logic [3:0] alucontrol,
    output logic       timeout,
    output logic [3:0] state
);
    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_RTEXEC = 4'd6,
        S_RTWB   = 4'd7,
        S_BRANCH = 4'd8,
        S_IEXEC  = 4'd9,
        S_IWB    = 4'd10,
        S_JUMP   = 4'd11,
        S_HALT   = 4'd12
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_SLL = 4'b1000;
    localparam logic [3:0] ALU_SRL = 4'b1001;

    localparam int CW = (MEM_WAIT_MAX > 1) ? $clog2(MEM_WAIT_MAX + 1) : 1;

    state_t        r_state;
    state_t        w_next;
    logic [CW-1:0] r_wait_cnt;
    logic          r_timeout;
    logic          w_rdy;
    logic          w_wait;
    logic          w_wd_fire;
    logic          w_trap;

    // Ready is masked during reset so no write enable can pulse in the reset cycle.
    assign w_rdy     = mem_ready & ~reset;
    assign w_wait    = mem_req & ~w_rdy;
    assign w_wd_fire = (MEM_WAIT_MAX != 0) && w_wait && ((int'(r_wait_cnt) + 1) == MEM_WAIT_MAX);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= S_FETCH;
            r_wait_cnt <= '0;
            r_timeout  <= 1'b0;
        end else begin
            r_state    <= w_next;
            r_wait_cnt <= w_wait ? (r_wait_cnt + CW'(1)) : '0;
            if (w_wd_fire || w_trap) begin
                r_timeout <= 1'b1;
            end
        end
    end

    always_comb begin
        w_next     = r_state;
        w_trap     = 1'b0;
        mem_req    = 1'b0;
        memwrite   = 1'b0;
        iord       = 1'b0;
        irwrite    = 1'b0;
        pcen       = 1'b0;
        pcsrc      = 2'b00;
        alusrca    = 1'b0;
        alusrcb    = 2'b00;
        zeroext    = 1'b0;
        shiftreg   = 1'b0;
        regdst     = 1'b0;
        memtoreg   = 1'b0;
        regwrite   = 1'b0;
        alucontrol = ALU_ADD;

        // IWB keeps the IEXEC ALU setup so the written result stays stable.
        if (r_state == S_IEXEC || r_state == S_IWB) begin
            alusrca = 1'b1;
            alusrcb = 2'b10;
            case (op)
                OP_SLTI: alucontrol = ALU_SLT;
                OP_ANDI: begin alucontrol = ALU_AND; zeroext = 1'b1; end
                OP_ORI:  begin alucontrol = ALU_OR;  zeroext = 1'b1; end
                default: alucontrol = ALU_ADD;
            endcase
        end

        case (r_state)
            S_FETCH: begin
                mem_req = 1'b1;
                alusrcb = 2'b01;
                if (w_wd_fire) begin
                    w_next = S_HALT;
                end else if (w_rdy) begin
                    irwrite = 1'b1;
                    pcen    = 1'b1;
                    w_next  = S_DECODE;
                end
            end
            S_DECODE: begin
                alusrcb = 2'b11;
                case (op)
                    OP_LW, OP_SW:                      w_next = S_MEMADR;
                    OP_RTYPE:                          w_next = S_RTEXEC;
                    OP_BEQ, OP_BNE:                    w_next = S_BRANCH;
                    OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI: w_next = S_IEXEC;
                    OP_J:                              w_next = S_JUMP;
                    default: begin
`ifdef MC_ILLEGAL_TRAP_EN
                        w_next = S_HALT;
                        w_trap = 1'b1;
`else
                        w_next = S_FETCH;
`endif
                    end
                endcase
            end
            S_MEMADR: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
                w_next  = (op == OP_SW) ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD, S_MEMWR: begin
                mem_req  = 1'b1;
                iord     = 1'b1;
                memwrite = (r_state == S_MEMWR);
                if (w_wd_fire) begin
                    w_next = S_HALT;
                end else if (w_rdy) begin
                    w_next = (r_state == S_MEMWR) ? S_FETCH : S_MEMWB;
                end
            end
            S_MEMWB: begin
                regwrite = 1'b1;
                memtoreg = 1'b1;
                w_next   = S_FETCH;
            end
            S_RTEXEC: begin
                alusrca = 1'b1;
                case (funct)
                    6'b100010: alucontrol = ALU_SUB;
                    6'b100100: alucontrol = ALU_AND;
                    6'b100101: alucontrol = ALU_OR;
                    6'b101010: alucontrol = ALU_SLT;
                    6'b000000: begin alucontrol = ALU_SLL; shiftreg = 1'b1; end
                    6'b000010: begin alucontrol = ALU_SRL; shiftreg = 1'b1; end
                    default:   alucontrol = ALU_ADD;
                endcase
                w_next = S_RTWB;
            end
            S_RTWB: begin
                regwrite = 1'b1;
                regdst   = 1'b1;
                w_next   = S_FETCH;
            end
            S_BRANCH: begin
                alusrca    = 1'b1;
                alucontrol = ALU_SUB;
                pcsrc      = 2'b01;
                pcen       = (op == OP_BNE) ? ~zero : zero;
                w_next     = S_FETCH;
            end
            S_IEXEC: w_next = S_IWB;
            S_IWB: begin
                regwrite = 1'b1;
                w_next   = S_FETCH;
            end
            S_JUMP: begin
                pcsrc  = 2'b10;
                pcen   = 1'b1;
                w_next = S_FETCH;
            end
            S_HALT: begin
                alucontrol = 4'b0000;
                w_next     = S_HALT;
            end
            default: w_next = S_FETCH;
        endcase
    end

    assign timeout = r_timeout;
    assign state   = r_state;
endmodule

// File: tb/tb_mc_controller.sv
// Directed bench for mc_controller (MEM_WAIT_MAX=4): walks each instruction class,
// wait states, async reset mid-store, watchdog expiry and the illegal-opcode path.
module tb_mc_controller;
    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
    logic       mem_ready;
    logic       mem_req, memwrite, iord, irwrite, pcen;
    logic [1:0] pcsrc, alusrcb;
    logic       alusrca, zeroext, shiftreg, regdst, memtoreg, regwrite;
    logic [3:0] alucontrol;
    logic       timeout;
    logic [3:0] state;

    int n_tests = 0;
    int n_fail  = 0;

    localparam logic [3:0] ST_FETCH = 4'd0, ST_DECODE = 4'd1, ST_MEMADR = 4'd2,
                           ST_MEMRD = 4'd3, ST_MEMWB = 4'd4, ST_MEMWR = 4'd5,
                           ST_RTEXEC = 4'd6, ST_RTWB = 4'd7, ST_BRANCH = 4'd8,
                           ST_IEXEC = 4'd9, ST_IWB = 4'd10, ST_JUMP = 4'd11,
                           ST_HALT = 4'd12;

    mc_controller #(.MEM_WAIT_MAX(4)) dut (
        .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
        .mem_ready(mem_ready), .mem_req(mem_req), .memwrite(memwrite),
        .iord(iord), .irwrite(irwrite), .pcen(pcen), .pcsrc(pcsrc),
        .alusrca(alusrca), .alusrcb(alusrcb), .zeroext(zeroext),
        .shiftreg(shiftreg), .regdst(regdst), .memtoreg(memtoreg),
        .regwrite(regwrite), .alucontrol(alucontrol), .timeout(timeout),
        .state(state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; op = 6'd0; funct = 6'd0; zero = 1'b0; mem_ready = 1'b0;
        #1;
        chk("rst_state", 32'(state), 32'(ST_FETCH));
        chk("rst_memreq", 32'(mem_req), 32'd1);
        chk("rst_alusrcb", 32'(alusrcb), 32'd1);
        chk("rst_aluctl", 32'(alucontrol), 32'b0010);
        chk("rst_timeout", 32'(timeout), 32'd0);
        chk("rst_wen", {28'd0, irwrite, pcen, regwrite, memwrite}, 32'd0);
        mem_ready = 1'b1;
        #1;
        chk("rst_rdy_wen", {30'd0, irwrite, pcen}, 32'd0);
        tick();
        reset = 1'b0;

        // lw, zero wait states
        op = 6'b100011;
        #1;
        chk("lw_fetch", {28'(state), irwrite, pcen, regwrite}, {28'(ST_FETCH), 3'b110});
        tick();
        chk("lw_decode", {28'(state), 2'(alusrcb), regwrite}, {28'(ST_DECODE), 3'b110});
        tick();
        chk("lw_memadr", {28'(state), alusrca, 2'(alusrcb)}, {28'(ST_MEMADR), 3'b110});
        tick();
        chk("lw_memrd", {28'(state), mem_req, iord, memwrite, regwrite}, {28'(ST_MEMRD), 4'b1100});
        tick();
        chk("lw_memwb", {28'(state), regwrite, memtoreg, regdst}, {28'(ST_MEMWB), 3'b110});
        tick();
        chk("lw_done", 32'(state), 32'(ST_FETCH));

        // fetch with 3 wait cycles, then beq taken
        op = 6'b000100; zero = 1'b1; mem_ready = 1'b0;
        #1;
        chk("wait1", {30'd0, irwrite, pcen}, 32'd0);
        tick();
        chk("wait2", {30'd0, irwrite, pcen}, 32'd0);
        tick();
        chk("wait3", {28'(state), irwrite, pcen}, {28'(ST_FETCH), 2'b00});
        tick();
        mem_ready = 1'b1;
        #1;
        chk("wait4_pulse", {28'(state), irwrite, pcen}, {28'(ST_FETCH), 2'b11});
        tick();
        chk("wait_after", {28'(state), irwrite, pcen}, {28'(ST_DECODE), 2'b00});
        tick();
        chk("beq_branch", {24'(state), 2'(pcsrc), pcen, alucontrol}, {24'(ST_BRANCH), 2'b01, 1'b1, 4'b0110});
        tick();

        // bne with zero=1: not taken
        op = 6'b000101;
        tick();
        tick();
        chk("bne_branch", {24'(state), 2'(pcsrc), pcen, alucontrol}, {24'(ST_BRANCH), 2'b01, 1'b0, 4'b0110});
        tick();

        // srl
        op = 6'b000000; funct = 6'b000010;
        tick();
        tick();
        chk("srl_exec", {24'(state), alucontrol, shiftreg, alusrca, 2'(alusrcb)}, {24'(ST_RTEXEC), 4'b1001, 2'b11, 2'b00});
        tick();
        chk("srl_wb", {28'(state), regdst, regwrite, memtoreg}, {28'(ST_RTWB), 3'b110});
        tick();

        // unlisted funct falls back to ADD
        funct = 6'b111111;
        tick();
        tick();
        chk("badfn_exec", {27'(state), alucontrol, shiftreg}, {27'(ST_RTEXEC), 4'b0010, 1'b0});
        tick();
        tick();

        // ori
        op = 6'b001101;
        tick();
        tick();
        chk("ori_exec", {24'(state), zeroext, alucontrol, 2'(alusrcb)}, {24'(ST_IEXEC), 1'b1, 4'b0001, 2'b10});
        tick();
        chk("ori_wb", {24'(state), regwrite, alucontrol, regdst}, {24'(ST_IWB), 1'b1, 4'b0001, 1'b0});
        tick();

        // j
        op = 6'b000010;
        tick();
        tick();
        chk("j_jump", {28'(state), 2'(pcsrc), pcen}, {28'(ST_JUMP), 2'b10, 1'b1});
        tick();
        chk("j_done", 32'(state), 32'(ST_FETCH));

        // sw stalled in MEMWR, then async reset
        op = 6'b101011;
        tick();
        tick();
        mem_ready = 1'b0;
        tick();
        chk("sw_memwr", {28'(state), mem_req, memwrite, iord}, {28'(ST_MEMWR), 3'b111});
        tick();
        reset = 1'b1;
        #1;
        chk("rst_mid_sw", {28'(state), mem_req, memwrite, timeout}, {28'(ST_FETCH), 3'b100});
        tick();
        reset = 1'b0;

        // watchdog: 4 stalled fetch cycles
        #1;
        tick();
        tick();
        tick();
        chk("wd_3", {28'(state), timeout}, {28'(ST_FETCH), 1'b0});
        tick();
        chk("wd_halt", {28'(state), timeout, mem_req}, {28'(ST_HALT), 2'b10});
        mem_ready = 1'b1;
        tick();
        chk("wd_stay", {24'(state), timeout, pcen, irwrite, alucontrol}, {24'(ST_HALT), 3'b100, 4'b0000});
        reset = 1'b1;
        #1;
        chk("wd_clear", {28'(state), timeout}, {28'(ST_FETCH), 1'b0});
        tick();
        reset = 1'b0;

        // unlisted opcode
        op = 6'b111111;
        tick();
        tick();
`ifdef MC_ILLEGAL_TRAP_EN
        chk("illegal_op", {28'(state), timeout}, {28'(ST_HALT), 1'b1});
`else
        chk("illegal_op", {28'(state), timeout}, {28'(ST_FETCH), 1'b0});
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
